// File: rtl/led_frame_streamer.sv
// Double-buffered LED frame store that feeds a WS2812B serializer one colour per LED in serpentine order.
// The write port fills the back bank; banks swap only at the end of the latch gap between frames.
module led_frame_streamer #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int LATCH_CYCLES = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [2:0]  wr_col,
  input  logic [23:0] wr_color,
  input  logic        frame_swap,
  input  logic        pix_done,
  output logic [23:0] pix_data,
  output logic        pix_load,
  output logic        frame_active,
  output logic        swap_pending,
  output logic        front_bank
);

  localparam int NUM_LEDS = ROWS * COLS;
  localparam int RW       = $clog2(ROWS);
  localparam int CW       = $clog2(COLS);
  localparam int IW       = RW + CW;
  localparam int AW       = IW + 1;
  localparam int LW       = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_LED   = IW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

  state_t        state;
  logic [IW-1:0] led_idx;
  logic [LW-1:0] latch_cnt;

  logic [23:0]   mem [0:(1<<AW)-1];
  logic [23:0]   rd_data;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] led_col;
  logic [RW-1:0] led_row;

  // ROWS is a power of two, so reversing the row in an odd column is a bitwise invert.
  assign led_col = led_idx[IW-1:RW];
  assign led_row = led_col[0] ? ~led_idx[RW-1:0] : led_idx[RW-1:0];
  assign rd_addr = {front_bank, led_col, led_row};
  assign wr_addr = {~front_bank, wr_col[CW-1:0], wr_row[RW-1:0]};

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_color;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      led_idx      <= '0;
      latch_cnt    <= '0;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      pix_data     <= '0;
      pix_load     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      pix_load <= 1'b0;
      if (frame_swap)
        swap_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (run) begin
            state        <= FETCH;
            led_idx      <= '0;
            frame_active <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          pix_data <= rd_data;
          pix_load <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (pix_done) begin
            if (led_idx == LAST_LED) begin
              state     <= LATCH;
              latch_cnt <= '0;
            end else begin
              led_idx <= led_idx + 1'b1;
              state   <= FETCH;
            end
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            // A request arriving on the swap cycle itself is kept for the next boundary.
            if (swap_pending) begin
              front_bank   <= ~front_bank;
              swap_pending <= frame_swap;
            end
            led_idx <= '0;
            if (run) begin
              state <= FETCH;
            end else begin
              state        <= IDLE;
              frame_active <= 1'b0;
            end
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Randomized bench for led_frame_streamer: a timestamp-level frame model predicts every output each cycle,
// and a few hand-derived literals pin the serpentine order, load spacing and swap behaviour.
module tb_led_frame_streamer;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int NUM   = ROWS * COLS;
  localparam int LATCH = 2400;
  localparam int WAIT_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset, run, wr_en, frame_swap, pix_done;
  logic [2:0]  wr_row, wr_col;
  logic [23:0] wr_color;
  logic [23:0] pix_data;
  logic        pix_load, frame_active, swap_pending, front_bank;

  led_frame_streamer #(.ROWS(ROWS), .COLS(COLS), .LATCH_CYCLES(LATCH)) dut (
    .clk(clk), .reset(reset), .run(run), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_color(wr_color), .frame_swap(frame_swap), .pix_done(pix_done), .pix_data(pix_data),
    .pix_load(pix_load), .frame_active(frame_active), .swap_pending(swap_pending),
    .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: tracks when the next load is due, which LED it carries, and when the latch gap ends.
  typedef enum int {M_IDLE, M_WAIT_LOAD, M_WAIT_DONE, M_LATCH} mmode_t;
  mmode_t      m_mode = M_IDLE;
  int          m_k = 0, m_load_at = 0, m_bnd = 0;
  bit          m_front = 0, m_pend = 0, m_active = 0;
  logic [23:0] m_cur = '0;
  bit          m_cur_val = 1;
  logic [23:0] m_mem [2][NUM];
  bit          m_val [2][NUM];
  logic [23:0] load_val [$];
  int          load_cyc [$];

  function automatic int serp(input int k);
    int c, r;
    c = k / ROWS;
    r = k % ROWS;
    if (c % 2 == 1) r = ROWS - 1 - r;
    return c * ROWS + r;
  endfunction

  always @(negedge clk) begin : compare
    bit exp_load, bnd_now;
    int p, back;
    cyc++;
    if (reset) begin
      m_mode = M_IDLE; m_k = 0; m_front = 0; m_pend = 0; m_active = 0;
      m_cur = '0; m_cur_val = 1;
    end
    exp_load = (m_mode == M_WAIT_LOAD) && (cyc == m_load_at);
    chk("pix_load", {31'd0, pix_load}, {31'd0, exp_load});
    if (exp_load) begin
      p = serp(m_k);
      m_cur_val = m_val[m_front ? 1 : 0][p];
      m_cur     = m_mem[m_front ? 1 : 0][p];
      load_val.push_back(pix_data);
      load_cyc.push_back(cyc);
    end
    if (m_cur_val) chk("pix_data", {8'd0, pix_data}, {8'd0, m_cur});
    chk("frame_active", {31'd0, frame_active}, {31'd0, m_active});
    chk("front_bank", {31'd0, front_bank}, {31'd0, m_front});
    chk("swap_pending", {31'd0, swap_pending}, {31'd0, m_pend});

    if (!reset) begin
      back = m_front ? 0 : 1;
      if (wr_en) begin
        m_mem[back][int'(wr_col) * ROWS + int'(wr_row)] = wr_color;
        m_val[back][int'(wr_col) * ROWS + int'(wr_row)] = 1;
      end
      bnd_now = (m_mode == M_LATCH) && (cyc == m_bnd);
      if (bnd_now && m_pend) begin
        m_front = !m_front;
        m_pend  = frame_swap;
      end else if (frame_swap) begin
        m_pend = 1;
      end
      if (m_mode == M_WAIT_LOAD && cyc == m_load_at) m_mode = M_WAIT_DONE;
      case (m_mode)
        M_IDLE: if (run) begin
          m_mode = M_WAIT_LOAD; m_load_at = cyc + 3; m_k = 0; m_active = 1;
        end
        M_WAIT_DONE: if (pix_done) begin
          if (m_k < NUM - 1) begin
            m_k++; m_load_at = cyc + 3; m_mode = M_WAIT_LOAD;
          end else begin
            m_mode = M_LATCH; m_bnd = cyc + LATCH;
          end
        end
        M_LATCH: if (bnd_now) begin
          m_k = 0;
          if (run) begin
            m_mode = M_WAIT_LOAD; m_load_at = cyc + 3;
          end else begin
            m_mode = M_IDLE; m_active = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // Serializer stand-in: answers each pix_load with a pix_done some cycles later.
  bit fixed_dly = 1;
  int stray_req = 0;
  int stray_ack = 0;
  initial begin : responder
    int d;
    pix_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && pix_load === 1'b1) begin
        d = fixed_dly ? 5 : int'($urandom_range(1, 9));
        repeat (d) @(posedge clk);
        #1 pix_done = 1'b1;
        @(posedge clk);
        #1 pix_done = 1'b0;
      end else if (stray_req != stray_ack) begin
        stray_ack++;
        @(posedge clk);
        #1 pix_done = 1'b1;
        @(posedge clk);
        #1 pix_done = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int r, input int c, input logic [23:0] v);
    wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_color = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    frame_swap = 1'b1;
    step();
    frame_swap = 1'b0;
  endtask

  task automatic wait_loads(input int n, input string name);
    int t;
    for (t = 0; t < WAIT_LIMIT && load_val.size() < n; t++) step();
    if (load_val.size() < n) chk(name, load_val.size(), n);
  endtask

  logic [23:0] bank0_vals [NUM];
  logic [23:0] serp_lit [16];

  initial begin : main
    int t, base, rel;
    serp_lit = '{24'h00, 24'h01, 24'h02, 24'h03, 24'h04, 24'h05, 24'h06, 24'h07,
                 24'h0F, 24'h0E, 24'h0D, 24'h0C, 24'h0B, 24'h0A, 24'h09, 24'h08};
    reset = 1'b1; run = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_color = '0;
    frame_swap = 1'b0;
    repeat (3) step();
    chk("reset_pix_data", {8'd0, pix_data}, 32'd0);
    chk("reset_pix_load", {31'd0, pix_load}, 32'd0);
    chk("reset_front_bank", {31'd0, front_bank}, 32'd0);
    chk("reset_frame_active", {31'd0, frame_active}, 32'd0);
    reset = 1'b0;
    step();

    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        write_px(r, c, {18'd0, 3'(c), 3'(r)});
    pulse_swap();
    run = 1'b1;

    // Frame 2 streams the coordinate pattern; refill bank 0 meanwhile and request two swaps.
    wait_loads(70, "wait_frame2");
    chk("front_after_first_latch", {31'd0, front_bank}, 32'd1);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        bank0_vals[c * ROWS + r] = (c == 4 && r == 3) ? 24'h00b000 : 24'($urandom);
        write_px(r, c, bank0_vals[c * ROWS + r]);
      end
    pulse_swap();
    repeat (4) step();
    pulse_swap();
    chk("double_swap_pending", {31'd0, swap_pending}, 32'd1);

    wait_loads(131, "wait_frame3");
    fixed_dly = 0;
    chk("single_swap_front", {31'd0, front_bank}, 32'd0);
    chk("single_swap_pending", {31'd0, swap_pending}, 32'd0);
    for (int i = 0; i < 16; i++) chk("serp_seq", {8'd0, load_val[64 + i]}, {8'd0, serp_lit[i]});
    chk("serp_col2_first", {8'd0, load_val[64 + 16]}, 32'h10);
    chk("serp_last", {8'd0, load_val[64 + 63]}, 32'h38);
    for (int i = 64; i < 127; i++) chk("load_spacing", load_cyc[i + 1] - load_cyc[i], 8);
    chk("latch_gap", load_cyc[128] - load_cyc[127], 5 + LATCH + 3);
    chk("front_pixel_untouched", {8'd0, load_val[64 + 35]}, 32'h23);

    // Frame 3: one early request, then a second exactly on the swap cycle.
    wait_loads(140, "wait_frame3_mid");
    pulse_swap();
    for (t = 0; t < WAIT_LIMIT && !(m_mode == M_LATCH && cyc + 1 == m_bnd); t++) step();
    if (t >= WAIT_LIMIT) chk("wait_swap_cycle", t, 0);
    chk("swapped_pixel", {8'd0, load_val[128 + 35]}, 32'h00b000);
    chk("bank0_led0", {8'd0, load_val[128]}, {8'd0, bank0_vals[0]});
    frame_swap = 1'b1;
    step();
    frame_swap = 1'b0;
    chk("exact_swap_front", {31'd0, front_bank}, 32'd1);
    chk("exact_swap_pending", {31'd0, swap_pending}, 32'd1);

    wait_loads(257, "wait_frame5");
    chk("second_toggle_front", {31'd0, front_bank}, 32'd0);
    chk("second_toggle_pending", {31'd0, swap_pending}, 32'd0);

    // Drop run at LED 20 of frame 5: the frame and its latch gap still complete.
    wait_loads(256 + 21, "wait_led20");
    for (t = 0; t < WAIT_LIMIT && !(m_mode == M_WAIT_DONE && m_k == 20); t++) step();
    run = 1'b0;
    for (t = 0; t < WAIT_LIMIT && m_mode != M_IDLE; t++) step();
    chk("frame_after_run_drop", load_val.size() - 256, NUM);
    chk("idle_frame_active", {31'd0, frame_active}, 32'd0);
    stray_req++;
    repeat (20) step();
    chk("no_load_in_idle", load_val.size(), 320);

    // Frame 6 swaps to bank 1, then reset lands in SEND at LED 30 of frame 7.
    pulse_swap();
    run = 1'b1;
    wait_loads(384 + 31, "wait_led30");
    for (t = 0; t < WAIT_LIMIT && !(m_mode == M_WAIT_DONE && m_k == 30); t++) step();
    chk("front_before_reset", {31'd0, front_bank}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_pix_load", {31'd0, pix_load}, 32'd0);
    chk("async_pix_data", {8'd0, pix_data}, 32'd0);
    chk("async_front_bank", {31'd0, front_bank}, 32'd0);
    chk("async_frame_active", {31'd0, frame_active}, 32'd0);
    repeat (15) step();
    base = load_val.size();
    reset = 1'b0;
    rel = cyc + 1;
    wait_loads(base + 10, "wait_restart");
    chk("restart_latency", load_cyc[base] - rel, 3);
    chk("restart_led0", {8'd0, load_val[base]}, {8'd0, bank0_vals[0]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
